paddle_motion_ctrl: RTL

//  Parametrised N-paddle motion controller; successor to the single-paddle mover.

---
 rtl/pong_pkg.sv | 26 ++
 rtl/paddle_channel.sv | 111 +++++++++++
 rtl/paddle_motion_ctrl.sv | 85 ++++++++
 3 files changed

// File: rtl/pong_pkg.sv
// Shared types and geometry helpers for the paddle motion slice.
// Imported by paddle_channel and paddle_motion_ctrl.
package pong_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } paddle_state_t;

    function automatic int min_center(
        input int top_margin,
        input int paddle_height
    );
        return top_margin + paddle_height / 2;
    endfunction

    function automatic int max_center(
        input int disp_rows,
        input int bottom_margin,
        input int paddle_height
    );
        return disp_rows - bottom_margin - paddle_height / 2;
    endfunction

endpackage

// File: rtl/paddle_channel.sv
// One paddle: direction FSM, step speed and clamped centre row.
// PADDLE_ACCEL_EN adds per-paddle acceleration; otherwise speed is 1.
module paddle_channel
    import pong_pkg::*;
#(
    parameter int ROW_W       = 12,
    parameter int DISP_ROWS   = 600,
    parameter int MIN_C       = 47,
    parameter int MAX_C       = 558,
    parameter int MAX_SPEED   = 4,
    parameter int ACCEL_TICKS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             up,
    input  logic             down,
    input  logic             recenter,
    output logic [ROW_W-1:0] center,
    output logic             at_top,
    output logic             at_bottom
);

    localparam int SPD_W = $clog2(MAX_SPEED + 1);
    localparam logic [ROW_W-1:0] HOME  = ROW_W'(DISP_ROWS / 2);
    localparam logic [ROW_W:0]   MIN_W = (ROW_W + 1)'(MIN_C);
    localparam logic [ROW_W:0]   MAX_W = (ROW_W + 1)'(MAX_C);

    paddle_state_t    state;
    paddle_state_t    req;
    logic [SPD_W-1:0] step;
    logic [ROW_W:0]   wide;
    logic [ROW_W:0]   stp;
    logic [ROW_W:0]   nxt_w;

    always_comb begin
        req = IDLE;
        unique case (1'b1)
            up && !down: req = UP;
            down && !up: req = DOWN;
            default:     req = IDLE;
        endcase
    end

`ifdef PADDLE_ACCEL_EN
    localparam int RUN_W = $clog2(ACCEL_TICKS + 1);

    logic [SPD_W-1:0] speed;
    logic [SPD_W-1:0] spd_nx;
    logic [RUN_W-1:0] run;
    logic [RUN_W-1:0] run_nx;
    logic             same;

    // run counts consecutive ticks in one direction since the last speed-up
    always_comb begin
        same   = (req == state);
        step   = same ? speed : SPD_W'(1);
        run_nx = same ? run + 1'b1 : RUN_W'(1);
        spd_nx = step;
        if (run_nx == RUN_W'(ACCEL_TICKS)) begin
            run_nx = '0;
            if (step != SPD_W'(MAX_SPEED))
                spd_nx = step + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || recenter) begin
            speed <= SPD_W'(1);
            run   <= '0;
        end else if (tick) begin
            if (req == IDLE) begin
                speed <= SPD_W'(1);
                run   <= '0;
            end else begin
                speed <= spd_nx;
                run   <= run_nx;
            end
        end
    end
`else
    assign step = SPD_W'(1);
`endif

    // one spare bit so neither direction can wrap before the clamp
    always_comb begin
        wide  = {1'b0, center};
        stp   = (ROW_W + 1)'(step);
        nxt_w = wide;
        case (req)
            UP:   nxt_w = (wide < MIN_W + stp) ? MIN_W : wide - stp;
            DOWN: nxt_w = (wide + stp > MAX_W) ? MAX_W : wide + stp;
            default: nxt_w = wide;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || recenter) begin
            center    <= HOME;
            state     <= IDLE;
            at_top    <= 1'b0;
            at_bottom <= 1'b0;
        end else if (tick) begin
            state     <= req;
            center    <= nxt_w[ROW_W-1:0];
            at_top    <= (nxt_w == MIN_W);
            at_bottom <= (nxt_w == MAX_W);
        end
    end

endmodule

// File: rtl/paddle_motion_ctrl.sv
// N-paddle motion controller: shared move tick, input synchronisers.
// Define PADDLE_ACCEL_EN to build per-paddle acceleration.
module paddle_motion_ctrl
    import pong_pkg::*;
#(
    parameter int NUM_PADDLES   = 2,
    parameter int DISP_ROWS     = 600,
    parameter int PADDLE_HEIGHT = 44,
    parameter int TOP_MARGIN    = 25,
    parameter int BOTTOM_MARGIN = 20,
    parameter int ROW_W         = 12,
    parameter int TICK_DIV      = 50000,
    parameter int MAX_SPEED     = 4,
    parameter int ACCEL_TICKS   = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_PADDLES-1:0]       move_up,
    input  logic [NUM_PADDLES-1:0]       move_down,
    input  logic [NUM_PADDLES-1:0]       recenter,
    output logic [NUM_PADDLES*ROW_W-1:0] paddle_center_row,
    output logic [NUM_PADDLES-1:0]       at_top,
    output logic [NUM_PADDLES-1:0]       at_bottom,
    output logic                         move_tick
);

    localparam int MIN_C = min_center(TOP_MARGIN, PADDLE_HEIGHT);
    localparam int MAX_C =
        max_center(DISP_ROWS, BOTTOM_MARGIN, PADDLE_HEIGHT);
    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0]       cnt;
    logic [NUM_PADDLES-1:0] up_s1;
    logic [NUM_PADDLES-1:0] up_s2;
    logic [NUM_PADDLES-1:0] dn_s1;
    logic [NUM_PADDLES-1:0] dn_s2;

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (cnt == CNT_LAST)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    assign move_tick = (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            up_s1 <= '0;
            up_s2 <= '0;
            dn_s1 <= '0;
            dn_s2 <= '0;
        end else begin
            up_s1 <= move_up;
            up_s2 <= up_s1;
            dn_s1 <= move_down;
            dn_s2 <= dn_s1;
        end
    end

    for (genvar i = 0; i < NUM_PADDLES; i++) begin : gen_ch
        paddle_channel #(
            .ROW_W      (ROW_W),
            .DISP_ROWS  (DISP_ROWS),
            .MIN_C      (MIN_C),
            .MAX_C      (MAX_C),
            .MAX_SPEED  (MAX_SPEED),
            .ACCEL_TICKS(ACCEL_TICKS)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .tick     (move_tick),
            .up       (up_s2[i]),
            .down     (dn_s2[i]),
            .recenter (recenter[i]),
            .center   (paddle_center_row[i*ROW_W +: ROW_W]),
            .at_top   (at_top[i]),
            .at_bottom(at_bottom[i])
        );
    end

endmodule
